// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the RMII receive path (and the future transmit framer).
package eth_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       err;
  } rx_beat_t;

endpackage

// File: rtl/rmii_rx_deframer_if.sv
// RMII receive pins plus the deframed byte stream handed to the MAC receive logic.
interface rmii_rx_deframer_if;

  logic       eth_crsdv;
  logic [1:0] eth_rxd;
  logic       eth_rxerr;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_err;

  // master: the deframer (consumes PHY pins, produces the byte stream)
  modport master (
    input  eth_crsdv, eth_rxd, eth_rxerr,
    output rx_data, rx_valid, rx_sof, rx_eof, rx_err
  );

  // slave: PHY side driver and byte stream consumer
  modport slave (
    output eth_crsdv, eth_rxd, eth_rxerr,
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_err
  );

endinterface

// File: rtl/eth_crc32.sv
// Byte-wise reflected CRC-32 next-state function, LSB of the byte processed first.
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;

  always_comb begin
    crc_work = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_work = (crc_work >> 1) ^ (((crc_work[0] ^ byte_in[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, assembles bytes, checks FCS and length,
// and emits a byte stream with sof/eof/err. Each byte is held back one slot so eof can ride on it.
module rmii_rx_deframer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522,
  parameter int PRE_MIN   = 4
) (
  input logic               clk_eth,
  input logic               rst_n,
  rmii_rx_deframer_if.master bus
);

  localparam int CNT_W = $clog2(MAX_FRAME + 2);

  logic             crsdv_reg, rxerr_reg;
  logic [1:0]       rxd_reg;

  rx_state_t        state_reg, state_next;

  logic [3:0]       pre_cnt_reg, pre_cnt_next;
  logic [1:0]       dib_cnt_reg, dib_cnt_next;
  logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic [5:0]       shift_reg, shift_next;
  logic [31:0]      crc_reg, crc_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [7:0]       pend_data_reg, pend_data_next;
  logic             pend_first_reg, pend_first_next;
  logic             rxerr_seen_reg, rxerr_seen_next;

  logic             valid_reg, valid_next;
  rx_beat_t         beat_reg, beat_next;

  logic [7:0]       byte_new;
  logic [31:0]      crc_new;
  logic             byte_done, oversize, sfd_ok;

  assign byte_new  = {rxd_reg, shift_reg};
  assign byte_done = (state_reg == DATA) && crsdv_reg && (dib_cnt_reg == 2'd3);
  assign oversize  = byte_done && (byte_cnt_reg == CNT_W'(MAX_FRAME));
  assign sfd_ok    = crsdv_reg && (rxd_reg == SFD_DIBIT) && (pre_cnt_reg >= 4'(PRE_MIN));

  eth_crc32 u_crc (
    .crc_in  (crc_reg),
    .byte_in (byte_new),
    .crc_out (crc_new)
  );

  // PHY pins are sampled once before anything looks at them
  always_ff @(posedge clk_eth or negedge rst_n) begin
    if (!rst_n) begin
      crsdv_reg <= 1'b0;
      rxd_reg   <= 2'b00;
      rxerr_reg <= 1'b0;
      valid_reg <= 1'b0;
      beat_reg  <= '0;
    end else begin
      crsdv_reg <= bus.eth_crsdv;
      rxd_reg   <= bus.eth_rxd;
      rxerr_reg <= bus.eth_rxerr;
      valid_reg <= valid_next;
      beat_reg  <= beat_next;
    end
  end

  always_ff @(posedge clk_eth or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_eth or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_reg    <= '0;
      dib_cnt_reg    <= '0;
      byte_cnt_reg   <= '0;
      shift_reg      <= '0;
      crc_reg        <= CRC_INIT;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
      pend_first_reg <= 1'b0;
      rxerr_seen_reg <= 1'b0;
    end else begin
      pre_cnt_reg    <= pre_cnt_next;
      dib_cnt_reg    <= dib_cnt_next;
      byte_cnt_reg   <= byte_cnt_next;
      shift_reg      <= shift_next;
      crc_reg        <= crc_next;
      pend_valid_reg <= pend_valid_next;
      pend_data_reg  <= pend_data_next;
      pend_first_reg <= pend_first_next;
      rxerr_seen_reg <= rxerr_seen_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (crsdv_reg && (rxd_reg == PRE_DIBIT)) state_next = PREAMBLE;
      end
      PREAMBLE: begin
        if (!crsdv_reg)                  state_next = IDLE;
        else if (rxd_reg == PRE_DIBIT)   state_next = PREAMBLE;
        else if (sfd_ok)                 state_next = DATA;
        else                             state_next = DROP;
      end
      DATA: begin
        if (!crsdv_reg)    state_next = IDLE;
        else if (oversize) state_next = DROP;
      end
      DROP: begin
        if (!crsdv_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pre_cnt_next    = pre_cnt_reg;
    dib_cnt_next    = dib_cnt_reg;
    byte_cnt_next   = byte_cnt_reg;
    shift_next      = shift_reg;
    crc_next        = crc_reg;
    pend_valid_next = pend_valid_reg;
    pend_data_next  = pend_data_reg;
    pend_first_next = pend_first_reg;
    rxerr_seen_next = rxerr_seen_reg | ((state_reg == DATA) && rxerr_reg);

    unique case (state_reg)
      IDLE: begin
        pre_cnt_next = 4'd1;
      end
      PREAMBLE: begin
        if (crsdv_reg && (rxd_reg == PRE_DIBIT) && (pre_cnt_reg != 4'd15)) begin
          pre_cnt_next = pre_cnt_reg + 4'd1;
        end
        if (sfd_ok) begin
          dib_cnt_next    = '0;
          byte_cnt_next   = '0;
          shift_next      = '0;
          crc_next        = CRC_INIT;
          pend_valid_next = 1'b0;
          pend_first_next = 1'b0;
          rxerr_seen_next = 1'b0;
        end
      end
      DATA: begin
        if (crsdv_reg) begin
          shift_next   = {rxd_reg, shift_reg[5:2]};
          dib_cnt_next = dib_cnt_reg + 2'd1;
          if (byte_done) begin
            crc_next        = crc_new;
            byte_cnt_next   = byte_cnt_reg + CNT_W'(1);
            pend_data_next  = byte_new;
            pend_valid_next = !oversize;
            pend_first_next = (byte_cnt_reg == '0);
          end
        end else begin
          pend_valid_next = 1'b0;
        end
      end
      DROP: begin
        pend_valid_next = 1'b0;
      end
      default: ;
    endcase
  end

  // Output beat is computed here and registered, so it appears the cycle after the deciding sample
  always_comb begin
    valid_next = 1'b0;
    beat_next  = '0;
    if ((state_reg == DATA) && pend_valid_reg) begin
      if (byte_done) begin
        valid_next     = 1'b1;
        beat_next.data = pend_data_reg;
        beat_next.sof  = pend_first_reg;
        beat_next.eof  = oversize;
        beat_next.err  = oversize;
      end else if (!crsdv_reg) begin
        valid_next     = 1'b1;
        beat_next.data = pend_data_reg;
        beat_next.sof  = pend_first_reg;
        beat_next.eof  = 1'b1;
        beat_next.err  = rxerr_seen_reg || rxerr_reg || (dib_cnt_reg != 2'd0)
                       || (byte_cnt_reg < CNT_W'(MIN_FRAME)) || (crc_reg != CRC_RESIDUE);
      end
    end
  end

  assign bus.rx_valid = valid_reg;
  assign bus.rx_data  = beat_reg.data;
  assign bus.rx_sof   = beat_reg.sof;
  assign bus.rx_eof   = beat_reg.eof;
  assign bus.rx_err   = beat_reg.err;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Directed frames on the RMII pins; a frame-level model predicts the emitted byte stream and flags.
module tb_rmii_rx_deframer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  rmii_rx_deframer_if bus ();

  rmii_rx_deframer #(
    .MIN_FRAME (64),
    .MAX_FRAME (1522),
    .PRE_MIN   (4)
  ) dut (
    .clk_eth (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] data;
    bit         sof;
    bit         eof;
    bit         err;
  } beat_t;

  int checks = 0;
  int failures = 0;
  int beats_seen = 0;
  int cycle = 0;
  int last_valid_cycle = 0;
  beat_t exp_q[$];
  logic [7:0] frame_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reflected CRC-32 register over the first n bytes of the frame buffer
  function automatic logic [31:0] crc_bytes(input int n);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = frame_q[i];
      for (int j = 0; j < 8; j++) begin
        if ((c[0] ^ b[j]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
        else                       c = c >> 1;
      end
    end
    return c;
  endfunction

  // n_data header+payload bytes followed by their FCS, least significant byte first
  task automatic build_frame(input int n_data);
    logic [31:0] fcs;
    frame_q.delete();
    for (int i = 0; i < n_data; i++) frame_q.push_back(i < 6 ? 8'hFF : 8'(i));
    fcs = ~crc_bytes(n_data);
    for (int i = 0; i < 4; i++) frame_q.push_back(fcs[8*i +: 8]);
  endtask

  function automatic bit err_model(input int n_full, input int partial, input bit rxerr);
    return rxerr || (partial != 0) || (n_full < 64) || (crc_bytes(n_full) != 32'hDEBB20E3);
  endfunction

  task automatic push_expect(input int n_emit, input bit has_eof, input bit err);
    beat_t e;
    for (int i = 0; i < n_emit; i++) begin
      e.data = frame_q[i];
      e.sof  = (i == 0);
      e.eof  = has_eof && (i == n_emit - 1);
      e.err  = has_eof && (i == n_emit - 1) && err;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && bus.rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {24'h0, bus.rx_data}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", {24'h0, bus.rx_data}, {24'h0, e.data});
        check("rx_sof", {31'h0, bus.rx_sof}, {31'h0, e.sof});
        check("rx_eof", {31'h0, bus.rx_eof}, {31'h0, e.eof});
        check("rx_err", {31'h0, bus.rx_err}, {31'h0, e.err});
      end
      if (!bus.rx_sof && !bus.rx_eof) check("beat_spacing", cycle - last_valid_cycle, 4);
      last_valid_cycle = cycle;
      beats_seen++;
    end
  end

  task automatic drive(input bit dv, input logic [1:0] d, input bit er);
    @(negedge clk);
    bus.eth_crsdv = dv;
    bus.eth_rxd   = d;
    bus.eth_rxerr = er;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_valid"}, {31'h0, bus.rx_valid}, 32'h0);
    check({name, "_flags"}, {29'h0, bus.rx_sof, bus.rx_eof, bus.rx_err}, 32'h0);
    check({name, "_data"}, {24'h0, bus.rx_data}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.eth_crsdv = 1'b0;
    bus.eth_rxd   = 2'b00;
    bus.eth_rxerr = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 check_outputs_zero("in_reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input int n_full, input int partial, input int rxerr_byte,
                            input int rst_byte, input int pre_n);
    logic [7:0] cur;
    bit stop;
    stop = 1'b0;
    for (int i = 0; i < pre_n; i++) drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
    for (int b = 0; b <= n_full && !stop; b++) begin
      cur = (b < frame_q.size()) ? frame_q[b] : 8'h00;
      for (int k = 0; k < 4 && !stop; k++) begin
        if (b == rst_byte && k == 3) begin
          do_reset();
          stop = 1'b1;
        end else if (b == n_full && k >= partial) begin
          stop = 1'b1;
        end else begin
          drive(1'b1, cur[2*k +: 2], (b == rxerr_byte) && (k == 0));
        end
      end
    end
    repeat (12) drive(1'b0, 2'b00, 1'b0);
  endtask

  task automatic finish_frame(input string name, input int beats_req);
    $display("frame %s: beats=%0d expected=%0d", name, beats_seen, beats_req);
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_beats"}, beats_seen, beats_req);
    exp_q.delete();
    beats_seen = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    string s;
    bus.eth_crsdv = 1'b0;
    bus.eth_rxd   = 2'b00;
    bus.eth_rxerr = 1'b0;

    // Pin the CRC model to the standard check value
    s = "123456789";
    frame_q.delete();
    for (int i = 0; i < s.len(); i++) frame_q.push_back(s[i]);
    c = ~crc_bytes(9);
    check("model_crc_check", c, 32'hCBF43926);

    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs_zero("idle");

    // Good 64-byte frame
    build_frame(60);
    check("model_residue", crc_bytes(64), 32'hDEBB20E3);
    check("model_good_err", {31'h0, err_model(64, 0, 1'b0)}, 32'h0);
    check("model_first_byte", {24'h0, frame_q[0]}, 32'h000000FF);
    push_expect(64, 1'b1, err_model(64, 0, 1'b0));
    send_frame(64, 0, -1, -1, 31);
    finish_frame("good", 64);

    // Payload byte 20 bit 3 corrupted after FCS was computed
    build_frame(60);
    frame_q[20] = frame_q[20] ^ 8'h08;
    check("model_badcrc_err", {31'h0, err_model(64, 0, 1'b0)}, 32'h1);
    push_expect(64, 1'b1, err_model(64, 0, 1'b0));
    send_frame(64, 0, -1, -1, 31);
    finish_frame("bad_fcs", 64);

    // Runt: 14 bytes plus valid FCS
    build_frame(14);
    check("model_runt_err", {31'h0, err_model(18, 0, 1'b0)}, 32'h1);
    push_expect(18, 1'b1, err_model(18, 0, 1'b0));
    send_frame(18, 0, -1, -1, 31);
    finish_frame("runt", 18);

    // PHY error pulse during byte 30
    build_frame(60);
    push_expect(64, 1'b1, err_model(64, 0, 1'b1));
    send_frame(64, 0, 30, -1, 31);
    finish_frame("rxerr", 64);

    // Carrier lost two dibits into byte 40
    build_frame(60);
    check("model_align_err", {31'h0, err_model(40, 2, 1'b0)}, 32'h1);
    push_expect(40, 1'b1, err_model(40, 2, 1'b0));
    send_frame(40, 2, -1, -1, 31);
    finish_frame("align", 40);

    // Too few preamble dibits before SFD
    build_frame(60);
    send_frame(64, 0, -1, -1, 2);
    finish_frame("short_pre", 0);

    // Reset three cycles while byte 25 is arriving: bytes 0..23 already emitted, no eof
    build_frame(60);
    push_expect(24, 1'b0, 1'b0);
    send_frame(64, 0, -1, 25, 31);
    finish_frame("reset_mid", 24);

    // Normal reception after the mid-frame reset
    build_frame(60);
    push_expect(64, 1'b1, err_model(64, 0, 1'b0));
    send_frame(64, 0, -1, -1, 31);
    finish_frame("after_reset", 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
